fsqrt_issue_ctrl: RTL and testbench

//   Issue controller and arbiter for the shared pipelined fsqrt unit (fixed latency, no stall input).
//   Two requesters (req0, req1) share the unit through a round-robin arbiter.
//   Tag and requester-id travel in a shadow valid pipeline that matches the fsqrt latency.

---
 rtl/fsqrt_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_fsqrt_issue_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_issue_ctrl.sv
// fsqrt_issue_ctrl: round-robin issue arbiter for a shared fixed-latency
// pipelined fsqrt unit, with a shadow tag pipeline and a credit-checked
// first-word-fall-through result FIFO.
// Ports:
//   clk, rstn              clock, async active-low reset
//   req0_*/req1_*          valid/ready operand + tag from the two requesters
//   sq_src, sq_dest        operand to / result from the fsqrt unit
//   res_valid/ready        FIFO head handshake
//   res_data/id/tag        FIFO head contents
//   busy                   ops in flight or FIFO non-empty
module fsqrt_issue_ctrl #(
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_src,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_src,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      sq_src,
   input  logic [31:0]      sq_dest,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_id,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

   logic [LATENCY-1:0] sh_valid;
   logic               sh_id  [LATENCY];
   logic [TAG_W-1:0]   sh_tag [LATENCY];

   logic [31:0]        mem_data [FIFO_DEPTH];
   logic               mem_id   [FIFO_DEPTH];
   logic [TAG_W-1:0]   mem_tag  [FIFO_DEPTH];
   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [PW:0]        count;

   logic               last;
   logic [31:0]        src_q;

   logic [CW-1:0]      inflight;
   logic               has_credit;
   logic               grant0;
   logic               grant1;
   logic               accept;
   logic               push;
   logic               pop;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++)
         inflight = inflight + CW'(sh_valid[i]);
   end

   // Registered state only: a pop this cycle frees its slot next cycle.
   assign has_credit = (CW'(count) + inflight) < CW'(FIFO_DEPTH);

   // last=1 means requester 1 won most recently, so 0 wins a tie.
   assign grant0 = req0_valid & (~req1_valid | last);
   assign grant1 = req1_valid & (~req0_valid | ~last);

   assign req0_ready = rstn & grant0 & has_credit;
   assign req1_ready = rstn & grant1 & has_credit;
   assign accept     = req0_ready | req1_ready;

   assign sq_src = grant0 ? req0_src :
                   grant1 ? req1_src : src_q;

   assign push      = sh_valid[LATENCY-1];
   assign res_valid = (count != '0);
   assign pop       = res_valid & res_ready;

   assign res_data = res_valid ? mem_data[rd_ptr] : '0;
   assign res_id   = res_valid ? mem_id[rd_ptr]   : 1'b0;
   assign res_tag  = res_valid ? mem_tag[rd_ptr]  : '0;

   assign busy = (|sh_valid) | res_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh_valid <= '0;
         last     <= 1'b1;
         src_q    <= '0;
      end else begin
         sh_valid[0] <= accept;
         for (int i = 1; i < LATENCY; i++)
            sh_valid[i] <= sh_valid[i-1];
         if (accept) begin
            last  <= req1_ready;
            src_q <= sq_src;
         end
      end
   end

   // Id/tag payload rides alongside sh_valid; qualified by it, no reset.
   always_ff @(posedge clk) begin
      sh_id[0]  <= req1_ready;
      sh_tag[0] <= req1_ready ? req1_tag : req0_tag;
      for (int i = 1; i < LATENCY; i++) begin
         sh_id[i]  <= sh_id[i-1];
         sh_tag[i] <= sh_tag[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= sq_dest;
         mem_id[wr_ptr]   <= sh_id[LATENCY-1];
         mem_tag[wr_ptr]  <= sh_tag[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// tb_fsqrt_issue_ctrl: directed vector table plus scoreboarded sequences
// for fsqrt_issue_ctrl, with a behavioural pipelined fsqrt in front of it.
module tb_fsqrt_issue_ctrl;

   localparam int LAT = 4;

   localparam logic [31:0] F025 = 32'h3E800000;
   localparam logic [31:0] F05  = 32'h3F000000;
   localparam logic [31:0] F1   = 32'h3F800000;
   localparam logic [31:0] F2   = 32'h40000000;
   localparam logic [31:0] F3   = 32'h40400000;
   localparam logic [31:0] F4   = 32'h40800000;
   localparam logic [31:0] F5   = 32'h40A00000;
   localparam logic [31:0] F8   = 32'h41000000;
   localparam logic [31:0] F9   = 32'h41100000;
   localparam logic [31:0] F16  = 32'h41800000;
   localparam logic [31:0] F25  = 32'h41C80000;
   localparam logic [31:0] F36  = 32'h42100000;
   localparam logic [31:0] F64  = 32'h42800000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_src;
   logic [4:0]  req0_tag;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_src;
   logic [4:0]  req1_tag;
   logic [31:0] sq_src, sq_dest;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_id;
   logic [4:0]  res_tag;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fsqrt_issue_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(4), .TAG_W(5)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_src(req0_src), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_src(req1_src), .req1_tag(req1_tag),
      .sq_src(sq_src), .sq_dest(sq_dest),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_id(res_id), .res_tag(res_tag),
      .busy(busy)
   );

   // IEEE single sqrt for positive normals (or zero), via double + RNE.
   function automatic logic [31:0] sqrt_ref(input logic [31:0] x);
      logic [63:0] d;
      logic [63:0] q;
      logic [7:0]  e;
      logic        rnd;
      real         r;
      if (x[30:0] == 31'd0) return x;
      d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      r = $sqrt($bitstoreal(d));
      q = $realtobits(r);
      e = 8'(q[62:52] - 11'd896);
      rnd = q[28] & (q[29] | (|q[27:0]));
      return {1'b0, e, q[51:29]} + 32'(rnd);
   endfunction

   // Behavioural fsqrt: LAT register stages, result at the last one.
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= sqrt_ref(sq_src);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sq_dest = pipe[LAT-1];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        r0v;
      logic [31:0] r0s;
      logic [4:0]  r0t;
      logic        r1v;
      logic [31:0] r1s;
      logic [4:0]  r1t;
      logic        rr;
      logic        e0;
      logic        e1;
      logic        ev;
      logic [31:0] ed;
      logic        eid;
      logic [4:0]  et;
      logic        eb;
   } vec_t;

   function automatic vec_t v(input int rs, input int a, input int as,
      input int at, input int b, input int bs, input int bt, input int rr,
      input int e0, input int e1, input int ev, input int ed, input int eid,
      input int et, input int eb);
      vec_t r;
      r.rst = 1'(rs); r.r0v = 1'(a); r.r0s = 32'(as); r.r0t = 5'(at);
      r.r1v = 1'(b); r.r1s = 32'(bs); r.r1t = 5'(bt); r.rr = 1'(rr);
      r.e0 = 1'(e0); r.e1 = 1'(e1); r.ev = 1'(ev); r.ed = 32'(ed);
      r.eid = 1'(eid); r.et = 5'(et); r.eb = 1'(eb);
      return r;
   endfunction

   typedef struct {
      logic        id;
      logic [4:0]  tag;
      logic [31:0] data;
   } exp_t;

   exp_t sbq[$];
   int   returned = 0;
   int   issued   = 0;

   task automatic sample();
      exp_t e;
      chk("one_grant", 32'(req0_ready & req1_ready), 32'd0);
      if (!req0_valid) chk("r0_ready_idle", 32'(req0_ready), 32'd0);
      if (!req1_valid) chk("r1_ready_idle", 32'(req1_ready), 32'd0);
      if (res_valid && res_ready) begin
         if (sbq.size() == 0) begin
            chk("unexpected_result", 32'(res_tag), 32'hFFFFFFFF);
         end else begin
            e = sbq.pop_front();
            returned++;
            chk("res_data", res_data, e.data);
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
         end
      end
      if (req0_valid && req0_ready) begin
         sbq.push_back('{1'b0, req0_tag, sqrt_ref(req0_src)});
         issued++;
      end
      if (req1_valid && req1_ready) begin
         sbq.push_back('{1'b1, req1_tag, sqrt_ref(req1_src)});
         issued++;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      req0_valid = 1'b0; req0_src = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_src = '0; req1_tag = '0;
      res_ready = 1'b0;
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         #2; sample();
         @(negedge clk);
      end
   endtask

   task automatic issue0(input logic [31:0] s, input logic [4:0] t);
      bit done;
      done = 1'b0;
      req0_valid = 1'b1; req0_src = s; req0_tag = t;
      for (int c = 0; c < 20 && !done; c++) begin
         #2;
         done = req0_ready;
         sample();
         @(negedge clk);
      end
      req0_valid = 1'b0;
      chk("issue0_done", 32'(done), 32'd1);
   endtask

   function automatic logic [31:0] rnd_op();
      return {1'b0, 8'($urandom_range(190, 64)), 23'($urandom)};
   endfunction

   vec_t tbl[$];

   initial begin
      bit          h0, h1, a0, a1, acc_now, stale;
      logic [31:0] s0, s1;
      logic [4:0]  t0, t1;
      int          acc;

      // test 1: single op from requester 0
      tbl.push_back(v(1, 1,F4,3, 0,0,0, 0, 1,0,0,0,0,0,0));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 0, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,1,F2,0,3,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,0,0,0,0,0));
      // test 2: both valid, alternating grants, credit stalls
      tbl.push_back(v(1, 1,F9,10, 1,F1,20, 1, 1,0,0,0,0,0,0));
      tbl.push_back(v(0, 1,F16,11, 1,F1,20, 1, 0,1,0,0,0,0,1));
      tbl.push_back(v(0, 1,F16,11, 1,F64,21, 1, 1,0,0,0,0,0,1));
      tbl.push_back(v(0, 1,F25,12, 1,F64,21, 1, 0,1,0,0,0,0,1));
      tbl.push_back(v(0, 1,F25,12, 1,F025,22, 1, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 1,F25,12, 1,F025,22, 1, 0,0,1,F3,0,10,1));
      tbl.push_back(v(0, 1,F25,12, 1,F025,22, 1, 1,0,1,F1,1,20,1));
      tbl.push_back(v(0, 1,F36,13, 1,F025,22, 1, 0,1,1,F4,0,11,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,1,F8,1,21,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,0,0,0,0,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,1,F5,0,12,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,1,F05,1,22,1));
      tbl.push_back(v(0, 0,0,0, 0,0,0, 1, 0,0,0,0,0,0,0));

      // reset state, with a requester already valid
      rstn = 1'b1;
      req0_valid = 1'b0; req0_src = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_src = '0; req1_tag = '0;
      res_ready = 1'b0;
      #1 rstn = 1'b0;
      req0_valid = 1'b1; req0_src = F4; req0_tag = 5'd7;
      #1;
      chk("rst_r0_ready", 32'(req0_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_tag", 32'(res_tag), 32'd0);
      @(negedge clk);

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         req0_valid = tbl[i].r0v; req0_src = tbl[i].r0s;
         req0_tag = tbl[i].r0t;
         req1_valid = tbl[i].r1v; req1_src = tbl[i].r1s;
         req1_tag = tbl[i].r1t;
         res_ready = tbl[i].rr;
         #2;
         chk($sformatf("row%0d r0_ready", i), 32'(req0_ready), 32'(tbl[i].e0));
         chk($sformatf("row%0d r1_ready", i), 32'(req1_ready), 32'(tbl[i].e1));
         chk($sformatf("row%0d res_valid", i), 32'(res_valid), 32'(tbl[i].ev));
         chk($sformatf("row%0d res_data", i), res_data, tbl[i].ed);
         chk($sformatf("row%0d res_id", i), 32'(res_id), 32'(tbl[i].eid));
         chk($sformatf("row%0d res_tag", i), 32'(res_tag), 32'(tbl[i].et));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].eb));
         @(negedge clk);
      end

      // test 3: stream into a stalled FIFO
      do_reset();
      acc = 0;
      req0_valid = 1'b1; req0_src = rnd_op(); req0_tag = 5'd0;
      for (int c = 0; c < 12; c++) begin
         #2;
         acc_now = req0_ready;
         sample();
         @(negedge clk);
         if (acc_now) begin
            acc++;
            req0_src = rnd_op();
            req0_tag = 5'(acc);
         end
      end
      // test 4: FIFO full, pop and request in the same cycle
      res_ready = 1'b1;
      #2;
      chk("t3_accepts", 32'(acc), 32'd4);
      chk("t4_wait_ready", 32'(req0_ready), 32'd0);
      chk("t4_full_valid", 32'(res_valid), 32'd1);
      sample();
      @(negedge clk);
      res_ready = 1'b0;
      #2;
      chk("t4_issue_ready", 32'(req0_ready), 32'd1);
      sample();
      @(negedge clk);
      req0_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 40 && (sbq.size() != 0 || busy); c++) begin
         #2; sample();
         @(negedge clk);
      end
      chk("t3_drained", 32'(sbq.size()), 32'd0);
      chk("t3_busy_end", 32'(busy), 32'd0);

      // test 5: reset with ops buffered and in flight
      do_reset();
      issue0(F9, 5'd1);
      issue0(F16, 5'd2);
      idle(4);
      issue0(F25, 5'd3);
      issue0(F36, 5'd4);
      chk("t5_pre_valid", 32'(res_valid), 32'd1);
      chk("t5_pre_busy", 32'(busy), 32'd1);
      rstn = 1'b0;
      req0_valid = 1'b1;
      #1;
      chk("t5_rst_valid", 32'(res_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ready", 32'(req0_ready), 32'd0);
      sbq.delete();
      req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      res_ready = 1'b1;
      stale = 1'b0;
      for (int c = 0; c < 12; c++) begin
         #2;
         if (res_valid || busy) stale = 1'b1;
         @(negedge clk);
      end
      chk("t5_no_stale", 32'(stale), 32'd0);

      // test 6: random traffic against the scoreboard
      do_reset();
      issued = 0;
      returned = 0;
      h0 = 1'b0; h1 = 1'b0;
      s0 = '0; s1 = '0; t0 = '0; t1 = '0;
      for (int c = 0; c < 400; c++) begin
         if (!h0 && $urandom_range(1, 0) == 1) begin
            h0 = 1'b1; s0 = rnd_op(); t0 = 5'($urandom);
         end
         if (!h1 && $urandom_range(1, 0) == 1) begin
            h1 = 1'b1; s1 = rnd_op(); t1 = 5'($urandom);
         end
         req0_valid = h0; req0_src = s0; req0_tag = t0;
         req1_valid = h1; req1_src = s1; req1_tag = t1;
         res_ready = ($urandom_range(3, 0) != 0);
         #2;
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         sample();
         if (a0) h0 = 1'b0;
         if (a1) h1 = 1'b0;
         @(negedge clk);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b1;
      for (int c = 0; c < 60 && (sbq.size() != 0 || busy); c++) begin
         #2; sample();
         @(negedge clk);
      end
      chk("t6_drained", 32'(sbq.size()), 32'd0);
      chk("t6_all_returned", 32'(returned), 32'(issued));
      chk("t6_progress", 32'(issued > 100), 32'd1);
      chk("t6_busy_end", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
